// File: rtl/aes_vector_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// aes_seq_pkg
// Shared types for the AES self-test vector sequencer.
//   state_t : sequencer FSM states
//   vec_t   : one stored test vector {key, plaintext, expected ciphertext}
//             at the default data width
// ----------------------------------------------------------------------------
package aes_seq_pkg;

    localparam int AES_DATA_W = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AES_DATA_W-1:0] key;
        logic [AES_DATA_W-1:0] pt;
        logic [AES_DATA_W-1:0] ct_exp;
    } vec_t;

endpackage

// File: rtl/aes_vector_sequencer_ram.sv
// ----------------------------------------------------------------------------
// aes_vec_ram
// Vector store: DEPTH entries of WIDTH bits, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset so a
// programmed vector set survives a sequencer reset.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write entry index
//   i_wdata  write data {key, pt, ct_exp}
//   i_raddr  read entry index
//   o_rdata  read data (combinational)
// ----------------------------------------------------------------------------
module aes_vec_ram #(
    parameter  int WIDTH = 384,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aes_vector_sequencer.sv
// ----------------------------------------------------------------------------
// aes_vector_sequencer
// On-chip AES self-test sequencer. Runs a programmed set of vectors through
// an AES core with a level-enable / valid handshake, compares each result with
// its expected ciphertext and accumulates pass / fail / timeout counts plus the
// index of the first failing vector.
// Ports:
//   AES_clk, AES_rst_n          clock, async active-low reset
//   cfg_we/addr/key/pt/ct_exp   vector store write port (blocked while busy)
//   start, num_vec              run request (num_vec clamped to DEPTH)
//   busy, done                  run status; done is a 1-cycle pulse
//   pass_cnt/fail_cnt/tmo_cnt   per-run result counters
//   first_fail_vld/idx          first failing or timed-out vector
//   AES_en/data_in/key_in       drive side of the core
//   AES_data_out/valid          result side of the core
//
// state   | meaning
// S_IDLE  | waiting for start
// S_DRIVE | AES_en high, waiting for valid or timeout
// S_GAP   | AES_en low for GAP cycles, then next vector or finish
// S_DONE  | one-cycle done pulse, back to idle
// ----------------------------------------------------------------------------
module aes_vector_sequencer
    import aes_seq_pkg::*;
#(
    parameter  int DATA_W  = AES_DATA_W,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 64,
    parameter  int GAP     = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic [DATA_W-1:0] cfg_pt,
    input  logic [DATA_W-1:0] cfg_ct_exp,
    input  logic              start,
    input  logic [IDX_W:0]    num_vec,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    pass_cnt,
    output logic [IDX_W:0]    fail_cnt,
    output logic [IDX_W:0]    tmo_cnt,
    output logic              first_fail_vld,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [IDX_W:0]   LP_DEPTH    = (IDX_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] LP_TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] LP_GAP_LAST = GAP_W'(GAP - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W:0]      r_num;
    logic [TMR_W-1:0]    r_tmr;
    logic [GAP_W-1:0]    r_gap;
    logic                r_busy;
    logic                r_done;
    logic [IDX_W:0]      r_pass_cnt;
    logic [IDX_W:0]      r_fail_cnt;
    logic [IDX_W:0]      r_tmo_cnt;
    logic                r_ff_vld;
    logic [IDX_W-1:0]    r_ff_idx;
    logic                r_en;
    logic [DATA_W-1:0]   r_data_in;
    logic [DATA_W-1:0]   r_key_in;

    logic                w_we;
    logic [IDX_W-1:0]    w_rd_addr;
    logic [3*DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0]   w_rd_key;
    logic [DATA_W-1:0]   w_rd_pt;
    logic [DATA_W-1:0]   w_rd_ct;
    logic [IDX_W:0]      w_num_clamp;
    logic                w_last;
    logic                w_match;

    // Store is frozen for the whole run so results depend only on what was
    // programmed before start.
    assign w_we = cfg_we & ~r_busy;

    // IDLE preloads entry 0, GAP preloads the next entry, DRIVE reads the
    // current entry's expected ciphertext.
    always_comb begin
        w_rd_addr = r_idx;
        if (r_state == S_IDLE) begin
            w_rd_addr = '0;
        end else if (r_state == S_GAP) begin
            w_rd_addr = r_idx + 1'b1;
        end
    end

    aes_vec_ram #(
        .WIDTH (3 * DATA_W),
        .DEPTH (DEPTH)
    ) u_vec_ram (
        .i_clk   (AES_clk),
        .i_we    (w_we),
        .i_waddr (cfg_addr),
        .i_wdata ({cfg_key, cfg_pt, cfg_ct_exp}),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign w_rd_key    = w_rd_data[3*DATA_W-1 -: DATA_W];
    assign w_rd_pt     = w_rd_data[2*DATA_W-1 -: DATA_W];
    assign w_rd_ct     = w_rd_data[DATA_W-1:0];
    assign w_num_clamp = (num_vec > LP_DEPTH) ? LP_DEPTH : num_vec;
    assign w_last      = ({1'b0, r_idx} == (r_num - 1'b1));
    assign w_match     = (AES_data_out == w_rd_ct);

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_num      <= '0;
            r_tmr      <= '0;
            r_gap      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
            r_en       <= 1'b0;
            r_data_in  <= '0;
            r_key_in   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pass_cnt <= '0;
                        r_fail_cnt <= '0;
                        r_tmo_cnt  <= '0;
                        r_ff_vld   <= 1'b0;
                        r_ff_idx   <= '0;
                        r_idx      <= '0;
                        r_tmr      <= '0;
                        r_num      <= w_num_clamp;
                        if (w_num_clamp != '0) begin
                            r_state   <= S_DRIVE;
                            r_busy    <= 1'b1;
                            r_en      <= 1'b1;
                            r_data_in <= w_rd_pt;
                            r_key_in  <= w_rd_key;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    // Valid has priority over a timeout in the same cycle.
                    if (AES_data_out_valid || (r_tmr == LP_TMO_LAST)) begin
                        if (AES_data_out_valid && w_match) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end else if (AES_data_out_valid) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                        if (!(AES_data_out_valid && w_match) && !r_ff_vld) begin
                            r_ff_vld <= 1'b1;
                            r_ff_idx <= r_idx;
                        end
                        r_en    <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == LP_GAP_LAST) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_data_in <= w_rd_pt;
                            r_key_in  <= w_rd_key;
                            r_tmr     <= '0;
                            r_en      <= 1'b1;
                            r_state   <= S_DRIVE;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign tmo_cnt        = r_tmo_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;
    assign AES_en         = r_en;
    assign AES_data_in    = r_data_in;
    assign AES_key_in     = r_key_in;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// ----------------------------------------------------------------------------
// tb_aes_vector_sequencer
// Drives the sequencer against a fixed-latency behavioural AES stand-in.
// Expected per-vector drive windows and per-run results are pushed to queues
// when a run is started and popped by a monitor as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_aes_vector_sequencer;
    import aes_seq_pkg::*;

    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int TMO   = 64;
    localparam int GAPC  = 2;
    localparam int LAT   = 11;

    localparam logic [DW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_key = '0;
    logic [DW-1:0] cfg_pt = '0;
    logic [DW-1:0] cfg_ct_exp = '0;
    logic          start = 1'b0;
    logic [IW:0]   num_vec = '0;
    logic          busy;
    logic          done;
    logic [IW:0]   pass_cnt;
    logic [IW:0]   fail_cnt;
    logic [IW:0]   tmo_cnt;
    logic          first_fail_vld;
    logic [IW-1:0] first_fail_idx;
    logic          AES_en;
    logic [DW-1:0] AES_data_in;
    logic [DW-1:0] AES_key_in;
    logic [DW-1:0] AES_data_out;
    logic          AES_data_out_valid;

    always #5 clk = ~clk;

    aes_vector_sequencer #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO),
        .GAP     (GAPC)
    ) dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .cfg_we             (cfg_we),
        .cfg_addr           (cfg_addr),
        .cfg_key            (cfg_key),
        .cfg_pt             (cfg_pt),
        .cfg_ct_exp         (cfg_ct_exp),
        .start              (start),
        .num_vec            (num_vec),
        .busy               (busy),
        .done               (done),
        .pass_cnt           (pass_cnt),
        .fail_cnt           (fail_cnt),
        .tmo_cnt            (tmo_cnt),
        .first_fail_vld     (first_fail_vld),
        .first_fail_idx     (first_fail_idx),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid)
    );

    // Behavioural core: FIPS-197 vector is answered exactly, anything else
    // goes through a cheap keyed mix. Valid appears in the LAT-th enabled cycle.
    function automatic logic [DW-1:0] model_fn(input logic [DW-1:0] k, input logic [DW-1:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return ({p[63:0], p[127:64]} ^ k) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    int unsigned m_cnt = 0;
    bit          m_never = 1'b0;

    always @(posedge clk) begin
        if (!AES_en) m_cnt <= 0;
        else         m_cnt <= m_cnt + 1;
    end

    assign AES_data_out_valid = AES_en && !m_never && (m_cnt == LAT - 1);
    assign AES_data_out       = AES_data_out_valid ? model_fn(AES_key_in, AES_data_in) : '0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int pass_n;
        int fail_n;
        int tmo_n;
        bit ffv;
        int ffi;
    } run_exp_t;

    typedef struct {
        logic [DW-1:0] key;
        logic [DW-1:0] pt;
        int            len;
    } vec_exp_t;

    run_exp_t run_q[$];
    vec_exp_t vec_q[$];
    vec_t     sh[DEPTH];

    bit       en_prev = 1'b0;
    bit       in_gap = 1'b0;
    int       hi_len = 0;
    int       lo_len = 0;
    int       rise_cnt = 0;
    int       n_done = 0;
    vec_exp_t mv;
    run_exp_t mr;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0;
            in_gap  = 1'b0;
        end else begin
            if (AES_en) begin
                if (!en_prev) begin
                    rise_cnt++;
                    if (in_gap) chk("gap_len", DW'(lo_len), DW'(GAPC));
                    in_gap = 1'b0;
                    hi_len = 0;
                    chk("drive_expected", DW'(vec_q.size() != 0), DW'(1));
                    if (vec_q.size() != 0) begin
                        chk("key_in", AES_key_in, vec_q[0].key);
                        chk("data_in", AES_data_in, vec_q[0].pt);
                    end
                end
                hi_len++;
            end else begin
                if (en_prev) begin
                    if (vec_q.size() != 0) begin
                        mv = vec_q.pop_front();
                        chk("en_len", DW'(hi_len), DW'(mv.len));
                        chk("key_hold", AES_key_in, mv.key);
                    end
                    in_gap = 1'b1;
                    lo_len = 0;
                end
                if (in_gap) lo_len++;
            end
            if (done) begin
                in_gap = 1'b0;
                n_done++;
                chk("done_expected", DW'(run_q.size() != 0), DW'(1));
                if (run_q.size() != 0) begin
                    mr = run_q.pop_front();
                    chk("pass_cnt", DW'(pass_cnt), DW'(mr.pass_n));
                    chk("fail_cnt", DW'(fail_cnt), DW'(mr.fail_n));
                    chk("tmo_cnt", DW'(tmo_cnt), DW'(mr.tmo_n));
                    chk("ff_vld", DW'(first_fail_vld), DW'(mr.ffv));
                    chk("ff_idx", DW'(first_fail_idx), DW'(mr.ffi));
                    chk("busy_at_done", DW'(busy), DW'(0));
                    chk("vec_left", DW'(vec_q.size()), DW'(0));
                end
            end
            en_prev = AES_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_entry(input int a, input vec_t v);
        @(posedge clk); #1;
        cfg_we     = 1'b1;
        cfg_addr   = IW'(a);
        cfg_key    = v.key;
        cfg_pt     = v.pt;
        cfg_ct_exp = v.ct_exp;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        sh[a]  = v;
    endtask

    task automatic start_run(input int n);
        int       cl;
        run_exp_t r;
        vec_exp_t v;
        logic [DW-1:0] out;
        cl = (n > DEPTH) ? DEPTH : n;
        r  = '{pass_n: 0, fail_n: 0, tmo_n: 0, ffv: 1'b0, ffi: 0};
        for (int i = 0; i < cl; i++) begin
            v.key = sh[i].key;
            v.pt  = sh[i].pt;
            if (m_never) begin
                v.len = TMO;
                r.tmo_n++;
            end else begin
                v.len = LAT;
                out   = model_fn(sh[i].key, sh[i].pt);
                if (out == sh[i].ct_exp) r.pass_n++;
                else                     r.fail_n++;
            end
            if (!r.ffv && (m_never || model_fn(sh[i].key, sh[i].pt) != sh[i].ct_exp)) begin
                r.ffv = 1'b1;
                r.ffi = i;
            end
            vec_q.push_back(v);
        end
        run_q.push_back(r);
        rise_cnt = 0;
        @(posedge clk); #1;
        start   = 1'b1;
        num_vec = (IW + 1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", DW'(busy), DW'(cl > 0));
        chk("en_after_start", DW'(AES_en), DW'(cl > 0));
        chk("done_after_start", DW'(done), DW'(cl == 0));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (run_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk("run_complete", DW'(run_q.size() == 0), DW'(1));
        run_q.delete();
        vec_q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        int   k;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_en", DW'(AES_en), DW'(0));
        chk("rst_pass", DW'(pass_cnt), DW'(0));
        chk("rst_ffv", DW'(first_fail_vld), DW'(0));
        chk("rst_data_in", AES_data_in, DW'(0));
        rst_n = 1'b1;

        // program store: entry 0 is the FIPS-197 vector
        v = '{key: FIPS_KEY, pt: FIPS_PT, ct_exp: FIPS_CT};
        write_entry(0, v);
        for (int i = 1; i < DEPTH; i++) begin
            v.key    = {$urandom, $urandom, $urandom, $urandom};
            v.pt     = {$urandom, $urandom, $urandom, $urandom};
            v.ct_exp = model_fn(v.key, v.pt);
            write_entry(i, v);
        end

        // 1: single FIPS vector
        n_done = 0;
        start_run(1);
        wait_done();
        chk("t1_done_pulses", DW'(n_done), DW'(1));

        // 2: four vectors, entry 2 expected value corrupted
        v = sh[2];
        v.ct_exp[0] = ~v.ct_exp[0];
        write_entry(2, v);
        start_run(4);
        wait_done();

        // 3: core never answers
        m_never = 1'b1;
        start_run(2);
        wait_done();
        m_never = 1'b0;

        // 4: zero vectors, then oversize request clamps to DEPTH
        start_run(0);
        wait_done();
        start_run(15);
        wait_done();

        // 5: start and cfg_we mid-run are ignored
        start_run(4);
        repeat (20) @(posedge clk);
        #1;
        start      = 1'b1;
        num_vec    = (IW + 1)'(1);
        cfg_we     = 1'b1;
        cfg_addr   = IW'(3);
        cfg_key    = {4{32'hdeadbeef}};
        cfg_pt     = {4{32'hcafef00d}};
        cfg_ct_exp = {4{32'h0badc0de}};
        @(posedge clk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        wait_done();
        start_run(4);
        wait_done();

        // 6: reset during DRIVE of vector 1, then rerun
        n_done = 0;
        start_run(4);
        k = 0;
        while (rise_cnt < 2 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("t6_reach_vec1", DW'(rise_cnt >= 2), DW'(1));
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pass_before", DW'(pass_cnt), DW'(1));
        vec_q.delete();
        run_q.delete();
        rst_n = 1'b0;
        #1;
        chk("t6_busy", DW'(busy), DW'(0));
        chk("t6_en", DW'(AES_en), DW'(0));
        chk("t6_pass", DW'(pass_cnt), DW'(0));
        chk("t6_key_in", AES_key_in, DW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("t6_no_done", DW'(n_done), DW'(0));
        start_run(4);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
